esp8266_at_seq: RTL and testbench

Sequencer that drives the ESP8266 UART transmitter with the fixed AT start-up script (`AT+CIPMUX=1\r\n`, then `AT+CIPSERVER=1,8080\r\n`), byte by byte, under a proper transmitter handshake. It sits directly upstream of the ESP8266 `uart_tx` and watches the ESP8266 `uart_rx` output for the `OK\r\n` reply after each command. It retries a command on timeout and reports done or error to the top level.

---
 rtl/esp8266_at_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_esp8266_at_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp8266_at_seq.sv
// esp8266_at_seq: plays the fixed ESP8266 AT start-up script into uart_tx,
// one byte at a time, and watches uart_rx for the "OK\r\n" reply after each
// command. On a reply timeout it resends the command, up to MAX_RETRY times.
// Build option: define ESP8266_AT_WAIT_OK_EN to compile in the OK matcher,
// the reply timeout and the retries. Without it, each command is followed
// by a fixed TIMEOUT_CYC wait and the script always advances.
// dbg_state exposes the FSM state for checkers.
module esp8266_at_seq #(
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 1_843_200,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_wrsig,
   input  logic       rx_int,
   input  logic [7:0] rx_data,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       cmd_idx,
   output logic [2:0] dbg_state
);

   // Transmit handshake: tx_data is stable from LOAD onwards. tx_wrsig is
   // high for the single SEND cycle. The byte counts as consumed only once
   // tx_busy has been seen high and then low again. No new strobe is issued
   // before that, so uart_tx is never written while it is shifting.

   localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_TX = 3'd3,
      ST_GAP     = 3'd4,
      ST_WAIT_OK = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERR     = 3'd7
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [5:0]      r_ptr;
   logic            r_cmd_idx;
   logic [7:0]      r_tx_data;
   logic            r_seen_busy;
   logic [GW-1:0]   r_gap_cnt;
   logic [TW-1:0]   r_timer;

   logic [5:0]      w_start_ptr;
   logic [5:0]      w_end_ptr;
   logic            w_last_byte;
   logic            w_gap_end;
   logic            w_timeout;

`ifdef ESP8266_AT_WAIT_OK_EN
   localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RW-1:0]   r_retry;
   logic            r_rx_int_d;
   logic [31:0]     r_window;
   logic            w_byte_evt;
   logic            w_match;
   logic            w_retry_left;
`else
   logic            w_unused_rx;
   assign w_unused_rx = ^{rx_int, rx_data};
`endif

   // Script ROM: command 0 at bytes 0-12, command 1 at bytes 13-33
   function automatic logic [7:0] rom_byte(input logic [5:0] a);
      case (a)
         6'd0:  rom_byte = 8'h41;  6'd1:  rom_byte = 8'h54;
         6'd2:  rom_byte = 8'h2B;  6'd3:  rom_byte = 8'h43;
         6'd4:  rom_byte = 8'h49;  6'd5:  rom_byte = 8'h50;
         6'd6:  rom_byte = 8'h4D;  6'd7:  rom_byte = 8'h55;
         6'd8:  rom_byte = 8'h58;  6'd9:  rom_byte = 8'h3D;
         6'd10: rom_byte = 8'h31;  6'd11: rom_byte = 8'h0D;
         6'd12: rom_byte = 8'h0A;
         6'd13: rom_byte = 8'h41;  6'd14: rom_byte = 8'h54;
         6'd15: rom_byte = 8'h2B;  6'd16: rom_byte = 8'h43;
         6'd17: rom_byte = 8'h49;  6'd18: rom_byte = 8'h50;
         6'd19: rom_byte = 8'h53;  6'd20: rom_byte = 8'h45;
         6'd21: rom_byte = 8'h52;  6'd22: rom_byte = 8'h56;
         6'd23: rom_byte = 8'h45;  6'd24: rom_byte = 8'h52;
         6'd25: rom_byte = 8'h3D;  6'd26: rom_byte = 8'h31;
         6'd27: rom_byte = 8'h2C;  6'd28: rom_byte = 8'h38;
         6'd29: rom_byte = 8'h30;  6'd30: rom_byte = 8'h38;
         6'd31: rom_byte = 8'h30;  6'd32: rom_byte = 8'h0D;
         6'd33: rom_byte = 8'h0A;
         default: rom_byte = 8'h00;
      endcase
   endfunction

   assign w_start_ptr = r_cmd_idx ? 6'd13 : 6'd0;
   assign w_end_ptr   = r_cmd_idx ? 6'd33 : 6'd12;
   assign w_last_byte = (r_ptr == w_end_ptr);
   assign w_gap_end   = (r_gap_cnt == GW'(GAP_CYC - 1));
   assign w_timeout   = (r_timer == TW'(TIMEOUT_CYC - 1));

`ifdef ESP8266_AT_WAIT_OK_EN
   // A received byte is valid on the falling edge of rx_int
   assign w_byte_evt   = r_rx_int_d & ~rx_int;
   assign w_match      = (r_window == 32'h4F4B0D0A);
   assign w_retry_left = (r_retry < RW'(MAX_RETRY));
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; in WAIT_OK a match takes priority over a timeout
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_LOAD;
         ST_LOAD:    w_next = ST_SEND;
         ST_SEND:    w_next = ST_WAIT_TX;
         ST_WAIT_TX: if (r_seen_busy && !tx_busy) w_next = ST_GAP;
         ST_GAP:     if (w_gap_end) w_next = w_last_byte ? ST_WAIT_OK : ST_LOAD;
         ST_WAIT_OK: begin
`ifdef ESP8266_AT_WAIT_OK_EN
            if (w_match)        w_next = r_cmd_idx ? ST_DONE : ST_LOAD;
            else if (w_timeout) w_next = w_retry_left ? ST_LOAD : ST_ERR;
`else
            if (w_timeout)      w_next = r_cmd_idx ? ST_DONE : ST_LOAD;
`endif
         end
         default:    w_next = ST_IDLE;
      endcase
   end

   // Datapath: byte pointer, command index, counters, OK window
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_cmd_idx   <= 1'b0;
         r_tx_data   <= 8'h00;
         r_seen_busy <= 1'b0;
         r_gap_cnt   <= '0;
         r_timer     <= '0;
`ifdef ESP8266_AT_WAIT_OK_EN
         r_retry     <= '0;
         r_rx_int_d  <= 1'b0;
         r_window    <= '0;
`endif
      end else begin
`ifdef ESP8266_AT_WAIT_OK_EN
         // Bytes are shifted in regardless of state; WAIT_OK entry clears
         r_rx_int_d <= rx_int;
         if (w_byte_evt) r_window <= {r_window[23:0], rx_data};
`endif
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  r_ptr     <= 6'd0;
                  r_cmd_idx <= 1'b0;
`ifdef ESP8266_AT_WAIT_OK_EN
                  r_retry   <= '0;
`endif
               end
            end
            ST_LOAD: begin
               r_tx_data   <= rom_byte(r_ptr);
               r_seen_busy <= 1'b0;
            end
            ST_WAIT_TX: begin
               if (tx_busy) r_seen_busy <= 1'b1;
            end
            ST_GAP: begin
               if (w_gap_end) begin
                  r_gap_cnt <= '0;
                  if (w_last_byte) begin
                     r_timer  <= '0;
`ifdef ESP8266_AT_WAIT_OK_EN
                     r_window <= '0;
`endif
                  end else begin
                     r_ptr <= r_ptr + 6'd1;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + GW'(1);
               end
            end
            ST_WAIT_OK: begin
               r_timer <= r_timer + TW'(1);
`ifdef ESP8266_AT_WAIT_OK_EN
               if (w_match) begin
                  if (!r_cmd_idx) begin
                     r_cmd_idx <= 1'b1;
                     r_ptr     <= 6'd13;
                     r_retry   <= '0;
                  end
               end else if (w_timeout && w_retry_left) begin
                  r_retry <= r_retry + RW'(1);
                  r_ptr   <= w_start_ptr;
               end
`else
               if (w_timeout && !r_cmd_idx) begin
                  r_cmd_idx <= 1'b1;
                  r_ptr     <= 6'd13;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state and datapath registers
   always_comb begin
      tx_data   = r_tx_data;
      tx_wrsig  = (r_state == ST_SEND);
      busy      = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
      done      = (r_state == ST_DONE);
`ifdef ESP8266_AT_WAIT_OK_EN
      error     = (r_state == ST_ERR);
`else
      error     = 1'b0;
`endif
      cmd_idx   = r_cmd_idx;
      dbg_state = r_state;
   end

endmodule

// File: tb/tb_esp8266_at_seq.sv
// Bench for esp8266_at_seq: uart_tx busy model, OK responder, strobe
// monitor, scenario table plus directed multi-cycle sequences.
module tb_esp8266_at_seq;

   localparam int GAP   = 16;
   localparam int TO    = 400;
   localparam int RETRY = 3;
   localparam int FRAME = 160;
   localparam int PER   = FRAME + GAP + 3;

   logic       clk;
   logic       rst;
   logic       start;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_wrsig;
   logic       rx_int;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       error;
   logic       cmd_idx;
   logic [2:0] dbg_state;

   esp8266_at_seq #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO), .MAX_RETRY(RETRY)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_wrsig(tx_wrsig), .rx_int(rx_int),
      .rx_data(rx_data), .busy(busy), .done(done), .error(error),
      .cmd_idx(cmd_idx), .dbg_state(dbg_state)
   );

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         st_cyc = 0;
   int         busy_len = FRAME;
   int         reply_mode = 0;
   int         reply_n = 0;
   logic       prev_wr = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         stb_cyc[$];
   logic [7:0] rom_tb [34] = '{
      8'h41, 8'h54, 8'h2B, 8'h43, 8'h49, 8'h50, 8'h4D, 8'h55, 8'h58, 8'h3D,
      8'h31, 8'h0D, 8'h0A,
      8'h41, 8'h54, 8'h2B, 8'h43, 8'h49, 8'h50, 8'h53, 8'h45, 8'h52, 8'h56,
      8'h45, 8'h52, 8'h3D, 8'h31, 8'h2C, 8'h38, 8'h30, 8'h38, 8'h30, 8'h0D,
      8'h0A};

   typedef struct {
      int   mode;
      int   exp_n;
      int   a0;
      int   a1;
      logic exp_done;
      logic exp_err;
      logic exp_cmd;
   } vec_t;
   vec_t vecs[3];

   // Clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // uart_tx model: busy rises after the strobe edge, stays high busy_len cycles
   initial begin : busy_model
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_wrsig) begin
            int len;
            len = busy_len;
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Strobe monitor: handshake rules and capture of {cmd_idx, tx_data}
   initial begin : strobe_mon
      forever begin
         @(negedge clk);
         if (tx_wrsig) begin
            check("wrsig_while_busy", tx_busy, 0);
            check("wrsig_back_to_back", prev_wr, 0);
            got_q.push_back({cmd_idx, tx_data});
            stb_cyc.push_back(cyc);
         end
         prev_wr = tx_wrsig;
      end
   end

   task automatic send_rx_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_int = 1'b1;
      repeat (8) @(posedge clk);
      #1 rx_int = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   // Responder: answers after each command's final 0x0A byte has gone out
   initial begin : responder
      rx_int = 1'b0;
      rx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_wrsig && tx_data == 8'h0A && reply_mode != 0) begin
            wait (tx_busy == 1'b1);
            wait (tx_busy == 1'b0);
            repeat (30) @(posedge clk);
            if (reply_mode == 2 && reply_n == 0) begin
               send_rx_byte(8'h4F); send_rx_byte(8'h4B);
               send_rx_byte(8'h0D); send_rx_byte(8'h58);
            end else if (reply_mode == 2 && reply_n == 1) begin
               send_rx_byte(8'h78); send_rx_byte(8'h78);
               send_rx_byte(8'h4F); send_rx_byte(8'h4B);
               send_rx_byte(8'h0D); send_rx_byte(8'h0A);
            end else begin
               send_rx_byte(8'h4F); send_rx_byte(8'h4B);
               send_rx_byte(8'h0D); send_rx_byte(8'h0A);
            end
            reply_n++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      st_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done || error) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_strobes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic build_exp(input int a0, input int a1);
      exp_q.delete();
      for (int a = 0; a < a0; a++)
         for (int i = 0; i < 13; i++) exp_q.push_back({1'b0, rom_tb[i]});
      for (int a = 0; a < a1; a++)
         for (int i = 13; i < 34; i++) exp_q.push_back({1'b1, rom_tb[i]});
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_tx_data"}, tx_data, 8'h00);
      check({tag, "_tx_wrsig"}, tx_wrsig, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_cmd_idx"}, cmd_idx, 0);
   endtask

   // Watchdog: the run must never hang
   initial begin
      #(10 * 95000);
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit ok;
      int n;
`ifdef ESP8266_AT_WAIT_OK_EN
      vecs[0] = '{1, 34, 1, 1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{0, 52, 4, 0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{2, 47, 2, 1, 1'b1, 1'b0, 1'b1};
`else
      vecs[0] = '{1, 34, 1, 1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{0, 34, 1, 1, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{2, 34, 1, 1, 1'b1, 1'b0, 1'b1};
`endif
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_outputs_reset("reset");

      // Scenario table: full script runs under different reply patterns
      for (int v = 0; v < 3; v++) begin
         reply_mode = vecs[v].mode;
         reply_n = 0;
         got_q.delete();
         stb_cyc.delete();
         build_exp(vecs[v].a0, vecs[v].a1);
         pulse_start();
         wait_end(40000, ok);
         check($sformatf("v%0d_end_reached", v), ok, 1);
         check($sformatf("v%0d_strobes", v), got_q.size(), vecs[v].exp_n);
         for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
               check($sformatf("v%0d_byte%0d", v, i), got_q[i], exp_q[i]);
         check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
         check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
         check($sformatf("v%0d_cmd_idx", v), cmd_idx, vecs[v].exp_cmd);
         check($sformatf("v%0d_busy", v), busy, 0);
         if (stb_cyc.size() >= 2) begin
            check($sformatf("v%0d_start_latency", v), stb_cyc[0] - st_cyc, 2);
            check($sformatf("v%0d_byte_period", v), stb_cyc[1] - stb_cyc[0], PER);
         end
         if (vecs[v].exp_err && stb_cyc.size() >= 14)
            check($sformatf("v%0d_retry_interval", v), stb_cyc[13] - stb_cyc[12], TO + PER);
      end

      // Long tx_busy: second strobe waits for busy to fall plus the gap
      reply_mode = 1;
      reply_n = 0;
      got_q.delete();
      stb_cyc.delete();
      busy_len = 1000;
      pulse_start();
      wait_strobes(1, 100, ok);
      check("hold_first_strobe", ok, 1);
      @(posedge clk);
      #2 busy_len = FRAME;
      repeat (500) @(negedge clk);
      check("hold_tx_data", tx_data, 8'h41);
      check("hold_no_second", got_q.size(), 1);
      wait_strobes(2, 2000, ok);
      check("hold_second_strobe", ok, 1);
      if (stb_cyc.size() >= 2) begin
         check("hold_period", stb_cyc[1] - stb_cyc[0], 1000 + GAP + 3);
         check("hold_second_byte", got_q[1], {1'b0, 8'h54});
      end
      pulse_rst();
      repeat (300) @(negedge clk);

      // Reset in the middle of command 1, byte 20
      reply_mode = 1;
      reply_n = 0;
      got_q.delete();
      stb_cyc.delete();
      pulse_start();
      wait_strobes(20, 20000, ok);
      check("rst_reach_byte20", ok, 1);
      repeat (5) @(negedge clk);
      check("rst_pre_cmd_idx", cmd_idx, 1);
      check("rst_pre_busy", busy, 1);
      pulse_rst();
      @(negedge clk);
      check_outputs_reset("rst_mid");
      n = got_q.size();
      repeat (2000) @(negedge clk);
      check("rst_no_more_strobes", got_q.size(), n);
      check("rst_still_idle_busy", busy, 0);
      pulse_start();
      wait_strobes(n + 1, 10, ok);
      check("rst_restart_strobe", ok, 1);
      if (got_q.size() > n) check("rst_restart_byte", got_q[n], {1'b0, 8'h41});
      wait_end(20000, ok);
      check("rst_restart_end", ok, 1);
      check("rst_restart_done", done, 1);
      check("rst_restart_strobes", got_q.size() - n, 34);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
